// File: rtl/mem_wb_ldq_if.sv
// ---------------------------------------------------------------------------
// mem_wb_ldq_if : MEM/WB load-queue bus (MEM inputs, memory return, WB outputs)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_wb_ldq_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 8,
  parameter int STALL_W = 6,
  parameter int OFF_W   = $clog2(DATA_W/8)
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [RADDR_W-1:0] mem_wd;
  logic               mem_wreg;
  logic [DATA_W-1:0]  mem_wdata;
  logic [OP_W-1:0]    mem_op;
  logic               mem_load;
  logic [1:0]         mem_ld_size;
  logic               mem_ld_uns;
  logic [OFF_W-1:0]   mem_ld_off;
  logic               mmem_valid;
  logic [DATA_W-1:0]  mmem_data;
  logic               stall_req;
  logic [RADDR_W-1:0] wb_wd;
  logic               wb_wreg;
  logic [DATA_W-1:0]  wb_wdata;
  logic [OP_W-1:0]    wb_op;

  modport master (
    output stall, flush, mem_wd, mem_wreg, mem_wdata, mem_op, mem_load,
           mem_ld_size, mem_ld_uns, mem_ld_off, mmem_valid, mmem_data,
    input  stall_req, wb_wd, wb_wreg, wb_wdata, wb_op
  );

  modport slave (
    input  stall, flush, mem_wd, mem_wreg, mem_wdata, mem_op, mem_load,
           mem_ld_size, mem_ld_uns, mem_ld_off, mmem_valid, mmem_data,
    output stall_req, wb_wd, wb_wreg, wb_wdata, wb_op
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_ldq.sv
// ---------------------------------------------------------------------------
// mem_wb_ldq : MEM/WB pipeline register with load-return wait FSM
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb_ldq #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int OP_W      = 8,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int OFF_W     = $clog2(DATA_W/8)
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mem_wb_ldq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [RADDR_W-1:0] r_p_wd;
  logic               r_p_wreg;
  logic [OP_W-1:0]    r_p_op;
  logic [1:0]         r_p_size;
  logic               r_p_uns;
  logic [OFF_W-1:0]   r_p_off;

  logic w_adv;
  logic w_bub;

  assign w_adv = !bus.stall[STAGE_IDX];
  assign w_bub = bus.stall[STAGE_IDX] && !bus.stall[STAGE_IDX+1];

  // Upper bits are pre-filled with the sign (or zero) and the field overwrites the bottom.
  function automatic logic [DATA_W-1:0] extract(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        size,
    input logic              uns,
    input logic [OFF_W-1:0]  off
  );
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] res;
    v   = data >> {off, 3'b000};
    res = '0;
    case (size)
      2'd0: begin
        res      = {DATA_W{v[7] & ~uns}};
        res[7:0] = v[7:0];
      end
      2'd1: begin
        res       = {DATA_W{v[15] & ~uns}};
        res[15:0] = v[15:0];
      end
      default: begin
        if (DATA_W == 64 && size == 2'd3) begin
          res = v;
        end else begin
          res       = {DATA_W{v[31] & ~uns}};
          res[31:0] = v[31:0];
        end
      end
    endcase
    return res;
  endfunction

  assign bus.stall_req = (r_state == ST_IDLE && bus.mem_load && w_adv && !bus.flush && !bus.mmem_valid)
                       || (r_state == ST_WAIT && !bus.mmem_valid && !bus.flush)
                       || (r_state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      bus.wb_wd    <= '0;
      bus.wb_wreg  <= 1'b0;
      bus.wb_wdata <= '0;
      bus.wb_op    <= '0;
      r_p_wd       <= '0;
      r_p_wreg     <= 1'b0;
      r_p_op       <= '0;
      r_p_size     <= '0;
      r_p_uns      <= 1'b0;
      r_p_off      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.flush || (!w_adv && w_bub) || (w_adv && bus.mem_load && !bus.mmem_valid)) begin
            bus.wb_wd    <= '0;
            bus.wb_wreg  <= 1'b0;
            bus.wb_wdata <= '0;
            bus.wb_op    <= '0;
            if (!bus.flush && w_adv) begin
              r_p_wd   <= bus.mem_wd;
              r_p_wreg <= bus.mem_wreg;
              r_p_op   <= bus.mem_op;
              r_p_size <= bus.mem_ld_size;
              r_p_uns  <= bus.mem_ld_uns;
              r_p_off  <= bus.mem_ld_off;
              r_state  <= ST_WAIT;
            end
          end else if (w_adv) begin
            bus.wb_wd   <= bus.mem_wd;
            bus.wb_wreg <= bus.mem_wreg;
            bus.wb_op   <= bus.mem_op;
            if (bus.mem_load)
              bus.wb_wdata <= extract(bus.mmem_data, bus.mem_ld_size, bus.mem_ld_uns, bus.mem_ld_off);
            else
              bus.wb_wdata <= bus.mem_wdata;
          end
        end
        ST_WAIT: begin
          // The stall vector has no say here: WB sees bubbles until the return lands.
          if (bus.mmem_valid && !bus.flush) begin
            bus.wb_wd    <= r_p_wd;
            bus.wb_wreg  <= r_p_wreg;
            bus.wb_op    <= r_p_op;
            bus.wb_wdata <= extract(bus.mmem_data, r_p_size, r_p_uns, r_p_off);
          end else begin
            bus.wb_wd    <= '0;
            bus.wb_wreg  <= 1'b0;
            bus.wb_wdata <= '0;
            bus.wb_op    <= '0;
          end
          if (bus.mmem_valid)
            r_state <= ST_IDLE;
          else if (bus.flush)
            r_state <= ST_DRAIN;
        end
        default: begin
          bus.wb_wd    <= '0;
          bus.wb_wreg  <= 1'b0;
          bus.wb_wdata <= '0;
          bus.wb_op    <= '0;
          if (bus.mmem_valid || r_state != ST_DRAIN)
            r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_ldq.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_ldq : directed self-checking bench for mem_wb_ldq
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_ldq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_wb_ldq_if #(.DATA_W(32), .RADDR_W(5), .OP_W(8), .STALL_W(6)) bus ();

  mem_wb_ldq #(
    .DATA_W(32), .RADDR_W(5), .OP_W(8), .STALL_W(6), .STAGE_IDX(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall       = '0;
    bus.flush       = 1'b0;
    bus.mem_wd      = '0;
    bus.mem_wreg    = 1'b0;
    bus.mem_wdata   = '0;
    bus.mem_op      = '0;
    bus.mem_load    = 1'b0;
    bus.mem_ld_size = '0;
    bus.mem_ld_uns  = 1'b0;
    bus.mem_ld_off  = '0;
    bus.mmem_valid  = 1'b0;
    bus.mmem_data   = '0;
  endtask

  task automatic issue_load(input logic [4:0] wd, input logic [1:0] size, input logic uns,
                            input logic [1:0] off);
    bus.stall       = '0;
    bus.mem_load    = 1'b1;
    bus.mem_wd      = wd;
    bus.mem_wreg    = 1'b1;
    bus.mem_op      = 8'h03;
    bus.mem_wdata   = 32'hCAFE_F00D;
    bus.mem_ld_size = size;
    bus.mem_ld_uns  = uns;
    bus.mem_ld_off  = off;
  endtask

  // Issue cycle plus (waits-1) WAIT cycles with stall_req high, then the return cycle.
  task automatic do_load(input string tag, input logic [4:0] wd, input logic [1:0] size,
                         input logic uns, input logic [1:0] off, input int waits,
                         input logic [31:0] data, input logic [31:0] exp);
    issue_load(wd, size, uns, off);
    #1 chk({tag, "_req_issue"}, 64'(bus.stall_req), 64'd1);
    tick();
    clear_inputs();
    for (int i = 0; i < waits - 1; i++) begin
      #1;
      chk({tag, "_req_wait"}, 64'(bus.stall_req), 64'd1);
      chk({tag, "_wreg_wait"}, 64'(bus.wb_wreg), 64'd0);
      tick();
    end
    bus.mmem_valid = 1'b1;
    bus.mmem_data  = data;
    #1 chk({tag, "_req_ret"}, 64'(bus.stall_req), 64'd0);
    tick();
    clear_inputs();
    chk({tag, "_wd"},    64'(bus.wb_wd),    64'(wd));
    chk({tag, "_wreg"},  64'(bus.wb_wreg),  64'd1);
    chk({tag, "_wdata"}, 64'(bus.wb_wdata), 64'(exp));
    chk({tag, "_op"},    64'(bus.wb_op),    64'h03);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wd",    64'(bus.wb_wd),     64'd0);
    chk("rst_wreg",  64'(bus.wb_wreg),   64'd0);
    chk("rst_wdata", 64'(bus.wb_wdata),  64'd0);
    chk("rst_op",    64'(bus.wb_op),     64'd0);
    chk("rst_req",   64'(bus.stall_req), 64'd0);

    // Non-load advance
    bus.mem_wd = 5; bus.mem_wreg = 1'b1; bus.mem_wdata = 32'hDEADBEEF; bus.mem_op = 8'h11;
    tick();
    clear_inputs();
    chk("nl_wd",    64'(bus.wb_wd),    64'd5);
    chk("nl_wreg",  64'(bus.wb_wreg),  64'd1);
    chk("nl_wdata", 64'(bus.wb_wdata), 64'hDEADBEEF);
    chk("nl_op",    64'(bus.wb_op),    64'h11);

    // Hold then bubble
    bus.mem_wd = 2; bus.mem_wreg = 1'b1; bus.mem_wdata = 32'h1234;
    tick();
    chk("pre_hold", 64'(bus.wb_wdata), 64'h1234);
    bus.stall = 6'b011000; bus.mem_wdata = 32'h5555; bus.mem_wd = 9;
    tick();
    chk("hold_wdata", 64'(bus.wb_wdata), 64'h1234);
    chk("hold_wd",    64'(bus.wb_wd),    64'd2);
    tick();
    chk("hold2_wreg", 64'(bus.wb_wreg), 64'd1);
    bus.stall = 6'b001000;
    tick();
    chk("bub_wreg",  64'(bus.wb_wreg),  64'd0);
    chk("bub_wdata", 64'(bus.wb_wdata), 64'd0);
    chk("bub_wd",    64'(bus.wb_wd),    64'd0);
    clear_inputs();

    // Waited loads: byte at off 2 of 0080FF11 is 80, byte at off 1 is FF
    do_load("lb_s_o2", 5'd7, 2'd0, 1'b0, 2'd2, 3, 32'h0080FF11, 32'hFFFFFF80);
    do_load("lb_u_o2", 5'd7, 2'd0, 1'b1, 2'd2, 3, 32'h0080FF11, 32'h00000080);
    do_load("lb_s_o1", 5'd7, 2'd0, 1'b0, 2'd1, 2, 32'h0080FF11, 32'hFFFFFFFF);
    do_load("lb_u_o1", 5'd7, 2'd0, 1'b1, 2'd1, 2, 32'h0080FF11, 32'h000000FF);
    // Misaligned half at off 3: only 0x80 survives, upper byte zero-filled, so positive
    do_load("lh_mis",  5'd8, 2'd1, 1'b0, 2'd3, 1, 32'h80000000, 32'h00000080);
    // D on a 32-bit datapath behaves as W
    do_load("ld_as_w", 5'd10, 2'd3, 1'b0, 2'd0, 2, 32'hA1B2C3D4, 32'hA1B2C3D4);

    // Zero-wait LH signed
    issue_load(5'd9, 2'd1, 1'b0, 2'd0);
    bus.mmem_valid = 1'b1; bus.mmem_data = 32'h00008001;
    #1 chk("zw_req", 64'(bus.stall_req), 64'd0);
    tick();
    clear_inputs();
    chk("zw_wdata", 64'(bus.wb_wdata), 64'hFFFF8001);
    chk("zw_wd",    64'(bus.wb_wd),    64'd9);
    chk("zw_wreg",  64'(bus.wb_wreg),  64'd1);
    #1 chk("zw_req_after", 64'(bus.stall_req), 64'd0);

    // Zero-wait unsigned byte at the top offset
    issue_load(5'd11, 2'd0, 1'b1, 2'd3);
    bus.mmem_valid = 1'b1; bus.mmem_data = 32'h9F000000;
    tick();
    clear_inputs();
    chk("zw_lbu_o3", 64'(bus.wb_wdata), 64'h0000009F);

    // Flush in WAIT, return arrives two cycles later and is dropped
    issue_load(5'd4, 2'd2, 1'b0, 2'd0);
    tick();
    clear_inputs();
    bus.flush = 1'b1;
    #1 chk("fl_req_flush", 64'(bus.stall_req), 64'd0);
    tick();
    bus.flush = 1'b0;
    #1 chk("fl_drain_req1", 64'(bus.stall_req), 64'd1);
    chk("fl_drain_wreg1", 64'(bus.wb_wreg), 64'd0);
    tick();
    chk("fl_drain_req2", 64'(bus.stall_req), 64'd1);
    chk("fl_drain_wreg2", 64'(bus.wb_wreg), 64'd0);
    bus.mmem_valid = 1'b1; bus.mmem_data = 32'hFFFFFFFF;
    tick();
    clear_inputs();
    chk("fl_ret_wreg",  64'(bus.wb_wreg),  64'd0);
    chk("fl_ret_wdata", 64'(bus.wb_wdata), 64'd0);
    #1 chk("fl_idle_req", 64'(bus.stall_req), 64'd0);
    bus.mem_wd = 3; bus.mem_wreg = 1'b1; bus.mem_wdata = 32'h33;
    tick();
    clear_inputs();
    chk("fl_next_wd",    64'(bus.wb_wd),    64'd3);
    chk("fl_next_wreg",  64'(bus.wb_wreg),  64'd1);
    chk("fl_next_wdata", 64'(bus.wb_wdata), 64'h33);

    // Flush and return together in WAIT
    issue_load(5'd12, 2'd2, 1'b0, 2'd0);
    tick();
    clear_inputs();
    bus.flush = 1'b1; bus.mmem_valid = 1'b1; bus.mmem_data = 32'h12345678;
    tick();
    clear_inputs();
    chk("flv_wreg", 64'(bus.wb_wreg), 64'd0);
    #1 chk("flv_req", 64'(bus.stall_req), 64'd0);

    // Reset mid-WAIT, later return ignored
    issue_load(5'd6, 2'd2, 1'b0, 2'd0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_wreg", 64'(bus.wb_wreg), 64'd0);
    chk("rw_req",  64'(bus.stall_req), 64'd0);
    bus.mmem_valid = 1'b1; bus.mmem_data = 32'hABCDEF01;
    tick();
    clear_inputs();
    chk("rw_ret_wreg",  64'(bus.wb_wreg),  64'd0);
    chk("rw_ret_wdata", 64'(bus.wb_wdata), 64'd0);

    // Stray return in IDLE under a non-load is ignored
    bus.mem_wd = 1; bus.mem_wreg = 1'b1; bus.mem_wdata = 32'h77;
    bus.mmem_valid = 1'b1; bus.mmem_data = 32'hAB;
    tick();
    clear_inputs();
    chk("stray_wdata", 64'(bus.wb_wdata), 64'h77);

    // WAIT ignores a hold on the stall vector
    issue_load(5'd13, 2'd1, 1'b1, 2'd2);
    tick();
    clear_inputs();
    bus.stall = 6'b011000;
    bus.mmem_valid = 1'b1; bus.mmem_data = 32'hBEEF0000;
    tick();
    clear_inputs();
    chk("wait_hold_wdata", 64'(bus.wb_wdata), 64'h0000BEEF);
    chk("wait_hold_wd",    64'(bus.wb_wd),    64'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
